// File: rtl/uart_tx_if.sv
// Request/status bundle between a byte source and the UART transmitter.
interface uart_tx_if;
    logic       i_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    modport master (
        output i_start,
        output i_data,
        input  o_tx,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_start,
        input  i_data,
        output o_tx,
        output o_tx_busy,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop
// bits; every bit is 16 b_tick pulses of the shared 16x baud tick.
module uart_tx #(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    uart_tx_if.slave   bus
);

    localparam bit   PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam bit   PAR_ODD   = (PARITY == 2);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [3:0]  tick_cnt, tick_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic        par_acc, par_n;
    logic        stop_cnt, stop_n;
    logic        fin, fin_n;
    logic        tx_c, busy_c;
    logic        tx_q, busy_q, done_q;

    function automatic logic parity_bit(input logic acc);
        return PAR_ODD ? ~acc : acc;
    endfunction

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_acc;
        stop_n  = stop_cnt;
        fin_n   = 1'b0;
        tx_c    = 1'b1;
        busy_c  = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                // A tick coinciding with acceptance is deliberately not counted.
                if (bus.i_start) begin
                    shift_n = bus.i_data;
                    tick_n  = 4'd0;
                    bit_n   = 3'd0;
                    par_n   = 1'b0;
                    stop_n  = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                tx_c = 1'b0;
                if (b_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) state_n = DATA;
                end
            end
            DATA: begin
                tx_c = shift[0];
                if (b_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_n = {1'b0, shift[7:1]};
                        par_n   = par_acc ^ shift[0];
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = PAR_EN ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                tx_c = parity_bit(par_acc);
                if (b_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) state_n = STOP;
                end
            end
            STOP: begin
                tx_c = 1'b1;
                if (b_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (stop_cnt == STOP_LAST) begin
                            state_n = IDLE;
                            fin_n   = 1'b1;
                        end else begin
                            stop_n = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line outputs are registered from the current state, one clk behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            par_acc  <= 1'b0;
            stop_cnt <= 1'b0;
            fin      <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_acc  <= par_n;
            stop_cnt <= stop_n;
            fin      <= fin_n;
            tx_q     <= tx_c;
            busy_q   <= busy_c;
            done_q   <= fin;
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = busy_q;
    assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants driven by one 16x tick (every 4 clk),
// each frame decoded at bit centres and compared with a bit-list model.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    logic b_tick = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic       start_r [4];
    logic [7:0] data_r  [4];
    logic       tx_v    [4];
    logic       busy_v  [4];
    logic       done_v  [4];

    int par_cfg [4] = '{0, 1, 2, 0};
    int sb_cfg  [4] = '{1, 1, 1, 2};

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();
    uart_tx_if bus3 ();

    uart_tx #(.PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .b_tick(b_tick), .bus(bus0));
    uart_tx #(.PARITY(1), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .b_tick(b_tick), .bus(bus1));
    uart_tx #(.PARITY(2), .STOP_BITS(1)) dut2 (.clk(clk), .rst(rst), .b_tick(b_tick), .bus(bus2));
    uart_tx #(.PARITY(0), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .b_tick(b_tick), .bus(bus3));

    assign bus0.i_start = start_r[0];
    assign bus1.i_start = start_r[1];
    assign bus2.i_start = start_r[2];
    assign bus3.i_start = start_r[3];
    assign bus0.i_data  = data_r[0];
    assign bus1.i_data  = data_r[1];
    assign bus2.i_data  = data_r[2];
    assign bus3.i_data  = data_r[3];
    assign tx_v[0] = bus0.o_tx;      assign busy_v[0] = bus0.o_tx_busy; assign done_v[0] = bus0.o_tx_done;
    assign tx_v[1] = bus1.o_tx;      assign busy_v[1] = bus1.o_tx_busy; assign done_v[1] = bus1.o_tx_done;
    assign tx_v[2] = bus2.o_tx;      assign busy_v[2] = bus2.o_tx_busy; assign done_v[2] = bus2.o_tx_done;
    assign tx_v[3] = bus3.o_tx;      assign busy_v[3] = bus3.o_tx_busy; assign done_v[3] = bus3.o_tx_done;

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            b_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Expected line levels of a whole frame, bit by bit.
    function automatic int build_frame(input logic [7:0] d, input int par, input int sb,
                                       output logic [11:0] bits);
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (par == 1) begin bits[n] = ^d;  n++; end
        if (par == 2) begin bits[n] = ~^d; n++; end
        for (int s = 0; s < ((sb == 2) ? 2 : 1); s++) begin bits[n] = 1'b1; n++; end
        return n;
    endfunction

    task automatic gap();
        int g;
        g = $urandom_range(0, 7);
        repeat (g) @(negedge clk);
    endtask

    task automatic issue(input int u, input logic [7:0] d);
        @(negedge clk);
        start_r[u] = 1'b1;
        data_r[u]  = d;
        @(negedge clk);
        start_r[u] = 1'b0;
        data_r[u]  = 8'($urandom);
    endtask

    // Follows one frame from its falling start edge to the o_tx_done cycle; returns there.
    task automatic check_frame(input int u, input logic [7:0] d, input bit inject, input string tag);
        logic [11:0] eb;
        logic [7:0]  got;
        int nb, w, n;
        bit seen_done;
        nb = build_frame(d, par_cfg[u], sb_cfg[u], eb);
        w = 0;
        while (tx_v[u] !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        checks++;
        if (tx_v[u] !== 1'b0) begin
            $display("FAIL %s start_edge: tx=%b, expected 0 within 10 clk", tag, tx_v[u]);
            failures++;
            return;
        end
        got = '0;
        seen_done = 1'b0;
        n = 0;
        while (n <= 64 * nb + 8) begin
            if (inject && n == 200) begin start_r[u] = 1'b1; data_r[u] = 8'hFF; end
            else begin start_r[u] = 1'b0; data_r[u] = 8'($urandom); end
            if (done_v[u] === 1'b1) begin seen_done = 1'b1; break; end
            if (n >= 32 && (n - 32) % 64 == 0 && (n - 32) / 64 < nb) begin
                int b;
                b = (n - 32) / 64;
                checks++;
                if (tx_v[u] !== eb[b] || busy_v[u] !== 1'b1) begin
                    $display("FAIL %s bit%0d: tx=%b busy=%b, expected tx=%b busy=1",
                             tag, b, tx_v[u], busy_v[u], eb[b]);
                    failures++;
                end
                if (b >= 1 && b <= 8) got[b - 1] = tx_v[u];
            end
            @(negedge clk);
            n++;
        end
        start_r[u] = 1'b0;
        checks++;
        if (!seen_done) begin
            $display("FAIL %s done_timeout: no o_tx_done within %0d clk", tag, 64 * nb + 8);
            failures++;
            return;
        end
        checks++;
        if (n < 64 * nb - 3 || n > 64 * nb) begin
            $display("FAIL %s frame_len: %0d clk, expected %0d..%0d", tag, n, 64 * nb - 3, 64 * nb);
            failures++;
        end
        checks++;
        if (tx_v[u] !== 1'b1 || busy_v[u] !== 1'b0) begin
            $display("FAIL %s end_state: tx=%b busy=%b, expected tx=1 busy=0", tag, tx_v[u], busy_v[u]);
            failures++;
        end
        checks++;
        if (got !== d) begin
            $display("FAIL %s decode: got %02h, expected %02h", tag, got, d);
            failures++;
        end
    endtask

    task automatic check_done_width(input int u, input string tag);
        @(negedge clk);
        checks++;
        if (done_v[u] !== 1'b0 || tx_v[u] !== 1'b1) begin
            $display("FAIL %s done_width: done=%b tx=%b, expected done=0 tx=1", tag, done_v[u], tx_v[u]);
            failures++;
        end
    endtask

    task automatic watch_quiet(input int u, input int cycles, input string tag);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_v[u] !== 1'b0 || tx_v[u] !== 1'b1 || busy_v[u] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL %s quiet: %0d cycles with activity, expected 0", tag, bad);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (tx_v[u] !== 1'b1 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0) begin
                $display("FAIL reset_u%0d: tx=%b busy=%b done=%b, expected 1 0 0",
                         u, tx_v[u], busy_v[u], done_v[u]);
                failures++;
            end
        end
        rst = 1'b0;
        for (int u = 0; u < 4; u++) watch_quiet(u, 20, "idle_ticks");
    endtask

    task automatic test_basic_55();
        issue(0, 8'h55);
        check_frame(0, 8'h55, 1'b0, "basic55");
        check_done_width(0, "basic55");
    endtask

    task automatic test_parity();
        gap(); issue(1, 8'h07); check_frame(1, 8'h07, 1'b0, "even07"); check_done_width(1, "even07");
        gap(); issue(2, 8'h07); check_frame(2, 8'h07, 1'b0, "odd07");  check_done_width(2, "odd07");
    endtask

    task automatic test_stop2();
        gap(); issue(3, 8'hA3); check_frame(3, 8'hA3, 1'b0, "stop2_a3"); check_done_width(3, "stop2_a3");
    endtask

    task automatic test_busy_ignore();
        gap(); issue(0, 8'h12);
        check_frame(0, 8'h12, 1'b1, "busy12");
        check_done_width(0, "busy12");
        watch_quiet(0, 300, "busy12_no_second");
    endtask

    task automatic test_back_to_back();
        gap(); issue(0, 8'hC3);
        check_frame(0, 8'hC3, 1'b0, "b2b_c3");
        start_r[0] = 1'b1;
        data_r[0]  = 8'h3C;
        @(negedge clk);
        start_r[0] = 1'b0;
        data_r[0]  = 8'($urandom);
        checks++;
        if (done_v[0] !== 1'b0) begin
            $display("FAIL b2b done_width: done=%b, expected 0", done_v[0]);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            $display("FAIL b2b start_latency: tx=%b busy=%b, expected tx=0 busy=1", tx_v[0], busy_v[0]);
            failures++;
        end
        check_frame(0, 8'h3C, 1'b0, "b2b_3c");
        check_done_width(0, "b2b_3c");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int w;
        d = 8'($urandom);
        gap(); issue(0, d);
        w = 0;
        while (tx_v[0] !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        repeat (32 + 64 * 5) @(negedge clk);
        checks++;
        if (tx_v[0] !== d[4] || busy_v[0] !== 1'b1) begin
            $display("FAIL rstmid bit4: tx=%b busy=%b, expected tx=%b busy=1", tx_v[0], busy_v[0], d[4]);
            failures++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            $display("FAIL rstmid async: tx=%b busy=%b done=%b, expected 1 0 0", tx_v[0], busy_v[0], done_v[0]);
            failures++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch_quiet(0, 150, "rstmid_after");
        d = 8'($urandom);
        gap(); issue(0, d);
        check_frame(0, d, 1'b0, "rstmid_clean");
        check_done_width(0, "rstmid_clean");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int r = 0; r < 3; r++) begin
            for (int u = 0; u < 4; u++) begin
                d = 8'($urandom);
                gap(); issue(u, d);
                check_frame(u, d, 1'b0, $sformatf("rand_u%0d_%02h", u, d));
                check_done_width(u, "rand");
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            start_r[u] = 1'b0;
            data_r[u]  = 8'h00;
        end
        rst = 1'b1;
        test_reset();
        test_basic_55();
        test_parity();
        test_stop2();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one byte per request onto a single TX line. It pairs with the UART receiver on the same link and shares its 16x-oversampled baud tick (`b_tick`) from the common baud generator. Frame format is start bit, 8 data bits LSB first, optional parity bit, and 1 or 2 stop bits. Each bit lasts exactly 16 `b_tick` pulses.

## Interface
Parameters:
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd. Value 3 is treated as none.
- `STOP_BITS`, default 1: 1 or 2. Any other value is treated as 1.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. Asynchronous, active-high.
- `b_tick` input 1: one-`clk`-wide pulse at 16x baud.
- `i_start` input 1: transmit request, sampled on `clk`.
- `i_data` input 8: byte to send, sampled only in the accept cycle.
- `o_tx` output 1: serial line, idle high.
- `o_tx_busy` output 1: high while a frame is in progress.
- `o_tx_done` output 1: one-cycle pulse at end of frame.

## Operation
- All outputs are registered.
- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- Internal registers:
  - 4-bit tick counter, wraps 15→0 at each bit boundary.
  - 3-bit data-bit counter.
  - 8-bit shift register.
  - parity accumulator.
  - stop-bit counter.
- State IDLE:
  - `o_tx`=1 and `o_tx_busy`=0.
  - If `i_start`=1, accept: latch `i_data` into the shift register, clear the counters, go to START.
- State START:
  - `o_tx`=0.
  - Each `b_tick` increments the tick counter.
  - On the `b_tick` where the counter is 15, go to DATA.
- State DATA:
  - `o_tx` = shift[0].
  - On the 16th `b_tick`: shift right, XOR the sent bit into parity, increment the bit counter.
  - After bit 7, go to PARITY if `PARITY` is 1 or 2, otherwise go to STOP.
- State PARITY:
  - `o_tx` = XOR of the data bits for even parity; the inverse of that XOR for odd parity.
  - Lasts 16 ticks, then go to STOP.
- State STOP:
  - `o_tx`=1.
  - Lasts 16 ticks × `STOP_BITS`.
  - On the final tick: go to IDLE, pulse `o_tx_done` for one `clk`.
- `i_start` outside IDLE is ignored. No queuing takes place, and `i_data` changes during a frame have no effect.
- `b_tick` is ignored in IDLE. The tick counter does not free-run between frames.

## Timing
- Acceptance latency:
  - `i_start` is sampled high at edge N while in IDLE.
  - At edge N+1, `o_tx`=0 and `o_tx_busy`=1.
  - Equivalently, the start bit begins one `clk` after the request.
- Start-bit length:
  - The start bit ends on the 16th `b_tick` after acceptance.
  - Its width is 16 tick periods minus the phase of the first tick, i.e. between 15 and 16 tick periods.
  - Every later bit is exactly 16 tick periods.
- Bit transitions happen on the `clk` edge following the qualifying `b_tick`, because outputs are registered.
- End of frame:
  - On the `clk` edge after the last stop-bit tick, `o_tx_busy`=0, `o_tx_done`=1, and `o_tx` stays 1.
  - `o_tx_done` lasts exactly one `clk`.
- Back-to-back frames:
  - `i_start` is accepted in the cycle where `o_tx_done`=1, since the block is already in IDLE.
  - The next start bit follows one `clk` later.
- Frame length is (1 + 8 + P + `STOP_BITS`) × 16 ticks, where P is 1 when parity is enabled and 0 otherwise.
- Reset mid-frame:
  - `o_tx` goes to 1 and `o_tx_busy` goes to 0 immediately (asynchronously).
  - No `o_tx_done` pulse is produced.
  - The partial frame is abandoned.
- `i_start` and `b_tick` in the same cycle in IDLE: accept normally. That tick is not counted toward the start bit.

## Test plan
Stimulus `b_tick` every 4 clk, so 1 bit = 64 clk.
- **0x55, PARITY=0, STOP_BITS=1:** pulse `i_start` with `i_data`=0x55. Required:
  - `o_tx` reads 0,1,0,1,0,1,0,1,0,1 at bit centers.
  - `o_tx_busy` is high for 10 bits.
  - One `o_tx_done` pulse, then `o_tx`=1.
- **Parity, `i_data`=0x07:**
  - PARITY=1 (even): parity bit is 1.
  - PARITY=2 (odd): parity bit is 0.
  - Frame length is 11 bits.
- **STOP_BITS=2, `i_data`=0xA3:**
  - Data bits on the line are 1,1,0,0,0,1,0,1.
  - Stop is high for 32 ticks before `o_tx_done`.
- **Request while busy:**
  - Send 0x12, then assert `i_start` with 0xFF mid-frame.
  - Required: 0x12 is transmitted intact, only one `o_tx_done` pulse, no second frame.
- **Back-to-back:**
  - Assert `i_start` with 0x3C in the `o_tx_done` cycle of a 0xC3 frame.
  - Required: the start bit begins 1 clk later, and both bytes decode correctly through the UART receiver in loopback.
- **Reset mid-frame:**
  - Assert `rst` during data bit 4.
  - Required: `o_tx`=1 and `o_tx_busy`=0 without waiting for a clk edge, no `o_tx_done` pulse, and the next request sends a clean frame.
